// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 inverse-cipher controller.
package aes_pkg;

   localparam int NR       = 10;
   localparam int SBOX_LAT = 3;
   localparam int CNT_W    = $clog2(SBOX_LAT);

   localparam logic [3:0]       NR_L     = 4'(NR);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_LAT - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KEXP  = 3'd1,
      ST_INIT  = 3'd2,
      ST_ROUND = 3'd3,
      ST_FINAL = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      DP_IDLE  = 2'd0,
      DP_INIT  = 2'd1,
      DP_MID   = 2'd2,
      DP_FINAL = 2'd3
   } dp_sel_t;

endpackage

// File: rtl/aes_inv_controller_nextstate.sv
// Combinational next-state, next-round and count-clear for the inverse-cipher sequencer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for load; key 0 written on the load cycle
// KEXP     | forward key expansion, one round key per SBOX_LAT cycles
// INIT     | initial AddRoundKey with round key NR
// ROUND    | inverse middle rounds NR-1 .. 1
// FINAL    | last inverse round with round key 0
// DONE     | plaintext valid; held until load drops
module aes_inv_controller_nextstate
   import aes_pkg::*;
(
   input  state_t                 state,
   input  logic [CNT_W-1:0]       count,
   input  logic [3:0]             round,
   input  logic                   load,
   output state_t                 state_nxt,
   output logic [3:0]             round_nxt,
   output logic                   cnt_clr
);

   logic last;
   assign last = (count >= CNT_LAST);

   always_comb begin
      state_nxt = ST_IDLE;
      round_nxt = 4'd0;
      cnt_clr   = 1'b1;
      case (state)
         ST_IDLE: begin
            if (load) begin
               state_nxt = ST_KEXP;
               round_nxt = 4'd1;
            end
         end
         ST_KEXP: begin
            state_nxt = ST_KEXP;
            round_nxt = round;
            cnt_clr   = last;
            if (last) begin
               if (round >= NR_L) begin
                  state_nxt = ST_INIT;
                  round_nxt = NR_L;
               end else begin
                  round_nxt = round + 4'd1;
               end
            end
         end
         ST_INIT: begin
            state_nxt = ST_ROUND;
            round_nxt = NR_L - 4'd1;
         end
         ST_ROUND: begin
            state_nxt = ST_ROUND;
            round_nxt = round;
            cnt_clr   = last;
            if (last) begin
               if (round <= 4'd1) begin
                  state_nxt = ST_FINAL;
                  round_nxt = 4'd0;
               end else begin
                  round_nxt = round - 4'd1;
               end
            end
         end
         ST_FINAL: begin
            state_nxt = last ? ST_DONE : ST_FINAL;
            cnt_clr   = last;
         end
         ST_DONE: begin
            state_nxt = load ? ST_DONE : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/aes_inv_controller.sv
// AES-128 inverse-cipher sequencer: key expansion into the round-key store,
// then inverse rounds NR..0. Control only; data lives in the datapath.
module aes_inv_controller
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   output logic [3:0] round,
   output logic       kexp_en,
   output logic       ks_we,
   output logic [3:0] ks_addr,
   output logic [1:0] dp_sel,
   output logic       dp_en,
   output logic       busy,
   output logic       done
);

   state_t           state_q, state_nxt;
   logic [3:0]       round_q, round_nxt;
   logic [CNT_W-1:0] count_q;
   logic             cnt_clr;
   logic             last;

   aes_inv_controller_nextstate u_nextstate (
      .state     (state_q),
      .count     (count_q),
      .round     (round_q),
      .load      (load),
      .state_nxt (state_nxt),
      .round_nxt (round_nxt),
      .cnt_clr   (cnt_clr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         round_q <= 4'd0;
         count_q <= '0;
      end else begin
         state_q <= state_nxt;
         round_q <= round_nxt;
         count_q <= cnt_clr ? '0 : count_q + CNT_W'(1);
      end
   end

   assign last = (count_q >= CNT_LAST);

   // Moore decode, except ks_we in IDLE which follows load directly so key 0
   // is captured in the same cycle the request is seen.
   always_comb begin
      round   = 4'd0;
      kexp_en = 1'b0;
      ks_we   = 1'b0;
      ks_addr = 4'd0;
      dp_sel  = DP_IDLE;
      dp_en   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ks_we = load;
         end
         ST_KEXP: begin
            round   = round_q;
            kexp_en = 1'b1;
            ks_we   = last;
            ks_addr = round_q;
            busy    = 1'b1;
         end
         ST_INIT: begin
            round   = round_q;
            ks_addr = NR_L;
            dp_sel  = DP_INIT;
            dp_en   = 1'b1;
            busy    = 1'b1;
         end
         ST_ROUND: begin
            round   = round_q;
            ks_addr = round_q;
            dp_sel  = DP_MID;
            dp_en   = last;
            busy    = 1'b1;
         end
         ST_FINAL: begin
            round   = round_q;
            dp_sel  = DP_FINAL;
            dp_en   = last;
            busy    = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            round = 4'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_inv_controller.sv
// Scoreboard bench for aes_inv_controller: stimulus pushes expected strobe events,
// a negedge monitor pops and compares them as the controller emits them.
module tb_aes_inv_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [3:0] round;
   logic       kexp_en;
   logic       ks_we;
   logic [3:0] ks_addr;
   logic [1:0] dp_sel;
   logic       dp_en;
   logic       busy;
   logic       done;

   aes_inv_controller dut (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .round   (round),
      .kexp_en (kexp_en),
      .ks_we   (ks_we),
      .ks_addr (ks_addr),
      .dp_sel  (dp_sel),
      .dp_en   (dp_en),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int addr;
   } ks_ev_t;

   typedef struct {
      int cyc;
      int sel;
      int rnd;
      int addr;
   } dp_ev_t;

   ks_ev_t ks_q[$];
   dp_ev_t dp_q[$];
   int     done_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Expected strobes for one transaction whose load is sampled in cycle t0.
   task automatic push_txn(input int t0);
      ks_ev_t k;
      dp_ev_t d;
      for (int i = 0; i <= 10; i++) begin
         k.cyc = t0 + 3 * i;
         k.addr = i;
         ks_q.push_back(k);
      end
      d = '{cyc: t0 + 31, sel: 1, rnd: 10, addr: 10};
      dp_q.push_back(d);
      for (int r = 9; r >= 1; r--) begin
         d = '{cyc: t0 + 32 + 3 * (9 - r) + 2, sel: 2, rnd: r, addr: r};
         dp_q.push_back(d);
      end
      d = '{cyc: t0 + 61, sel: 3, rnd: 0, addr: 0};
      dp_q.push_back(d);
      done_q.push_back(t0 + 62);
   endtask

   // Monitor
   ks_ev_t mk;
   dp_ev_t md;
   int     mdone;
   logic   done_prev = 1'b0;
   int     n_busy = 0, n_sel1 = 0, n_sel2 = 0, n_sel3 = 0;

   always @(negedge clk) begin
      if (ks_we) begin
         if (ks_q.size() == 0) chk("ks_we_unexpected", 1, 0);
         else begin
            mk = ks_q.pop_front();
            chk("ks_we_cycle", cyc, mk.cyc);
            chk("ks_we_addr", int'(ks_addr), mk.addr);
         end
      end
      if (dp_en) begin
         if (dp_q.size() == 0) chk("dp_en_unexpected", 1, 0);
         else begin
            md = dp_q.pop_front();
            chk("dp_en_cycle", cyc, md.cyc);
            chk("dp_en_sel", int'(dp_sel), md.sel);
            chk("dp_en_round", int'(round), md.rnd);
            chk("dp_en_ks_addr", int'(ks_addr), md.addr);
         end
      end
      if (busy) begin
         n_busy++;
         if (dp_sel == 2'd1) n_sel1++;
         if (dp_sel == 2'd2) n_sel2++;
         if (dp_sel == 2'd3) n_sel3++;
      end
      if (done && !done_prev) begin
         if (done_q.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            mdone = done_q.pop_front();
            chk("done_cycle", cyc, mdone);
            chk("busy_cycles", n_busy, 61);
            chk("dp_sel1_cycles", n_sel1, 1);
            chk("dp_sel2_cycles", n_sel2, 27);
            chk("dp_sel3_cycles", n_sel3, 3);
         end
         n_busy = 0; n_sel1 = 0; n_sel2 = 0; n_sel3 = 0;
      end
      if (reset) begin
         n_busy = 0; n_sel1 = 0; n_sel2 = 0; n_sel3 = 0;
      end
      done_prev = done;
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_round"}, int'(round), 0);
      chk({tag, "_kexp_en"}, int'(kexp_en), 0);
      chk({tag, "_ks_we"}, int'(ks_we), 0);
      chk({tag, "_ks_addr"}, int'(ks_addr), 0);
      chk({tag, "_dp_sel"}, int'(dp_sel), 0);
      chk({tag, "_dp_en"}, int'(dp_en), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   task automatic start_txn(output int t0);
      @(posedge clk);
      #1;
      load = 1'b1;
      t0 = cyc;
      push_txn(t0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   int t0;

   initial begin
      reset = 1'b1;
      load  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single-cycle load pulse, then back to IDLE.
      start_txn(t0);
      @(posedge clk);
      #1;
      load = 1'b0;
      wait_done();
      @(posedge clk);
      @(negedge clk);
      chk("idle_after_done_done", int'(done), 0);
      chk("idle_after_done_busy", int'(busy), 0);

      // Load held past done: controller parks in DONE until load falls.
      start_txn(t0);
      wait_done();
      repeat (5) begin
         @(negedge clk);
         chk("hold_done", int'(done), 1);
         chk("hold_busy", int'(busy), 0);
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      @(negedge clk);
      chk("drop_load_still_done", int'(done), 1);
      @(negedge clk);
      chk("drop_load_idle_done", int'(done), 0);
      chk("drop_load_idle_round", int'(round), 0);

      // Re-raise with load toggling through KEXP and ROUND; timing must not change.
      start_txn(t0);
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         load = i[0];
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      wait_done();

      // Reset in the middle of ROUND (cycle 40).
      start_txn(t0);
      @(posedge clk);
      #1;
      load = 1'b0;
      while (cyc != t0 + 40) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("midreset");
      ks_q.delete();
      dp_q.delete();
      done_q.delete();

      // Fresh transaction after the reset.
      start_txn(t0);
      @(posedge clk);
      #1;
      load = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);

      chk("ks_q_drained", ks_q.size(), 0);
      chk("dp_q_drained", dp_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_inv_controller.md
# aes_inv_controller

Sequencing FSM for the AES-128 inverse cipher (decryption) datapath: the decrypt-side counterpart of the encrypt controller. On a load request it first runs forward key expansion, storing round keys 0–10 into the round-key store. It then drives the inverse rounds 10→0 and raises `done`. It issues only control (round index, key-store write/address, datapath selects/enables); state and key data live in the datapath.

## Interface
- `NR`, 10: number of cipher rounds (AES-128).
- `SBOX_LAT`, 3: cycles per round spent through the synchronous S-box path (key expansion and InvSubBytes).
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  request; new key/ciphertext valid in datapath while high.
- `round`  out  4  current round index driven to the datapath.
- `kexp_en`  out  1  advance key-expansion register.
- `ks_we`  out  1  round-key store write strobe.
- `ks_addr`  out  4  round-key store address (write during expansion, read during decryption).
- `dp_sel`  out  2  datapath step: 0 idle, 1 initial AddRoundKey, 2 middle round, 3 final round.
- `dp_en`  out  1  capture datapath state register.
- `busy`  out  1  high from load acceptance until `done`.
- `done`  out  1  plaintext valid.

## Operation
- States: IDLE, KEXP, INIT, ROUND, FINAL, DONE. Next-state logic is a pure function of state, cycle count, round, and `load`.
- IDLE
  - With `load`=1: `ks_we`=1 and `ks_addr`=0 in the same cycle (combinational from `load`), storing key 0.
  - Next state KEXP, round=1, count=0.
- KEXP
  - `kexp_en`=1 on every cycle.
  - On count==SBOX_LAT-1: `ks_we`=1, `ks_addr`=round; then round+1 and count=0.
  - After writing round NR: go to INIT with round=NR.
- INIT: one cycle. `ks_addr`=NR, `dp_sel`=1, `dp_en`=1. Next: ROUND with round=NR-1.
- ROUND
  - `ks_addr`=round, `dp_sel`=2.
  - `dp_en`=1 only on count==SBOX_LAT-1; at that point round decrements.
  - Leaving round 1 → FINAL with round=0.
- FINAL
  - `ks_addr`=0, `dp_sel`=3, `dp_en` on the last count.
  - Then DONE.
- DONE
  - `done`=1; `busy`=0; other outputs 0.
  - Stays in DONE while `load`=1; goes to IDLE on the first cycle with `load`=0.
  - A new transaction therefore requires `load` to fall and rise again.
- `load` is ignored in every state except IDLE and DONE. Deasserting it mid-operation has no effect.
- Count is 2 bits (`$clog2(SBOX_LAT)`). It resets to 0 on every state or round change. It never exceeds SBOX_LAT-1.
- Round is 4-bit unsigned and never wraps. Out-of-range state values go to IDLE with all outputs 0.

## Timing
- Reset value of every output and register is 0: state IDLE, round 0, count 0.
- Reset asserted mid-operation: IDLE on the next edge. Key store contents are not cleared.
- Taking cycle 0 as the IDLE cycle where `load` is sampled:
  - KEXP: cycles 1–30.
  - INIT: cycle 31.
  - ROUND 9…1: cycles 32–58.
  - FINAL: cycles 59–61.
  - `done` first high at cycle 62.
- Total latency is 62 cycles. General form: 1 + NR·SBOX_LAT + 1 + (NR-1)·SBOX_LAT + SBOX_LAT.
- `ks_we` pulses exactly NR+1 times per transaction, at addresses 0,1,…,10 in order.
- `dp_en` pulses exactly NR+1 times per transaction.
- All outputs are Moore outputs of state/count/round, except the IDLE `ks_we` (Mealy on `load`).

## Structure
- Shared `aes_pkg`:
  - `typedef enum logic [2:0]` for the states.
  - Constants NR and SBOX_LAT.
  - `dp_sel` encodings, named.
- Sub-module `aes_inv_controller_nextstate`: combinational next state, next round, and count-clear.
- Top level: state/round/count registers and output decode.

## Test plan
- Reset, then `load` pulse at cycle 0 → `ks_we` at cycles 0,3,6,…,30 with `ks_addr` 0–10; `done` rises at cycle 62; `busy` high cycles 1–61.
- Decrypt the FIPS-197 C.1 vector through the datapath (key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a) → plaintext 00112233445566778899aabbccddeeff.
- Hold `load` high past `done` → controller stays in DONE; drop `load` → IDLE next cycle; re-raise `load` → second transaction with identical timing.
- Assert `reset` at cycle 40 (ROUND) → all outputs 0 next cycle; a fresh `load` afterwards completes in 62 cycles.
- Toggle `load` during KEXP and ROUND → no change in `ks_we`, `dp_en`, or round sequence.
- Across the transaction → `dp_sel` sequence is 1 once, 2 for 27 cycles, 3 for 3 cycles; round sequence is 10, 9…1, 0.
